median_rr_arbiter: RTL and testbench
====================================

// Module: median_rr_arbiter
// PURPOSE
//  Shares one combinational 3-input median unit (MCD) among N_REQ requesters.
//  Round-robin grant, valid/ready handshakes, 2-stage pipeline: operand register -> MCD -> result register.
//  Sits between the sample producers and the single MCD instance; MCD is external, driven via mcd_* ports.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
//  W      8  operand/median width in bits
//  IDW    2  requester-id width, must satisfy 2**IDW >= N_REQ
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        asynchronous active-low reset
//  req_valid   in   N_REQ    requester i has operands pending
//  req_ready   out  N_REQ    one-hot grant; transfer on req_valid[i] & req_ready[i]
//  req_a       in   N_REQ*W  operand a, requester i at [i*W +: W]
//  req_b       in   N_REQ*W  operand b, same packing
//  req_c       in   N_REQ*W  operand c, same packing
//  mcd_a/b/c   out  W each   operands driven to shared MCD (straight from operand register)
//  mcd_median  in   W        MCD result, combinational from mcd_a/b/c
//  res_valid   out  1        result register holds a result
//  res_ready   in   1        downstream accepts; transfer on res_valid & res_ready
//  res_id      out  IDW      requester index the result belongs to
//  res_data    out  W        median value
// BEHAVIOUR
//  Reset: req_ready=0, mcd_a/b/c=0, res_valid=0, res_id=0, res_data=0, RR pointer=0, in-flight work discarded.
//  Reset mid-operation: same values immediately (async); operands accepted before reset are lost, never output.
//  Stage 1 (op_valid,op_id,op_a/b/c) drives mcd_*. Stage 2 captures mcd_median, op_id into res_*.
//  Advance rules: s2_load = op_valid & (~res_valid | res_ready);
//   s1_free = ~op_valid | s2_load; req_ready[g]=1 only for granted g when s1_free, all others 0.
//  Grant: search req_valid starting at pointer, upward mod N_REQ; first set bit wins; combinational.
//  Pointer: after accept from g, pointer <= (g+1) mod N_REQ; no accept -> pointer unchanged.
//  Latency: accept at edge k -> res_valid=1 from edge k+1 if stage 2 free; full throughput 1 result/cycle.
//  Backpressure: res_valid & ~res_ready holds res_*; stage 1 holds op regs and mcd_* stable; req_ready=0.
//  Occupancy FSM (from op_valid,res_valid): EMPTY(0,0) -> S1(1,0) on accept; S1 -> S2 or FULL;
//   FULL(1,1): only exits when res_ready=1 (then simultaneous s2_load + new accept permitted).
//  Simultaneous drain and accept in same cycle is required (no bubble). Never drop or duplicate a result.
//  res_data must equal median(a,b,c) of the accepted triple; ties return the repeated value.
//  No request valid: req_ready=0, pointer unchanged; req_valid may drop without grant (no stickiness).
// CONFIGURATION
//  MEDIAN_ARB_STATS_EN defined: adds output done_cnt[15:0]; +1 on each res_valid&res_ready,
//   saturates at 16'hFFFF, resets to 0 on rst_n=0.
//  Not defined: port done_cnt absent, no counter logic; all other behaviour identical.
// TESTING
//  T1 single: req_valid=4'b0001, a=8'h20,b=8'h80,c=8'h04, res_ready=1 -> next cycle res_valid=1, res_id=0, res_data=8'h20.
//  T2 RR fairness: req_valid=4'b1111 held 8 cycles, res_ready=1 -> grant order 0,1,2,3,0,1,2,3, one result/cycle.
//  T3 pointer wrap: pointer=3, req_valid=4'b0101 -> grant 0, then 2; no grant to idle 3.
//  T4 backpressure: res_ready=0 with 2 accepts -> FULL, req_ready=4'b0000, mcd_*/res_* stable; res_ready=1 -> drain, in order, no loss.
//  T5 ties: a=b=8'h10,c=8'hFF -> res_data=8'h10; a=8'h01,b=8'h80,c=8'h20 -> 8'h20.
//  T6 reset mid-flight: rst_n=0 while FULL -> all outputs 0 immediately, pointer 0, first grant after release goes to lowest valid id; STATS build: done_cnt=0.

Source files
------------

// File: rtl/median_rr_arbiter.sv
// Round-robin front end sharing one external 3-input median unit among N_REQ requesters.
// Optional completion counter on done_cnt when MEDIAN_ARB_STATS_EN is defined.
module median_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ*W-1:0] req_c,
    output logic [W-1:0]       mcd_a,
    output logic [W-1:0]       mcd_b,
    output logic [W-1:0]       mcd_c,
    input  logic [W-1:0]       mcd_median,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [W-1:0]       res_data
`ifdef MEDIAN_ARB_STATS_EN
    ,
    output logic [15:0]        done_cnt
`endif
);

    // State encoding is {op_valid, res_valid}
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        S2    = 2'b01,
        S1    = 2'b10,
        FULL  = 2'b11
    } occ_t;

    occ_t           state;
    occ_t           state_nxt;
    logic           op_valid;
    logic [IDW-1:0] op_id;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   op_c;
    logic [IDW-1:0] ptr;
    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic           s1_free;
    logic           s2_load;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   sel_c;

    assign op_valid  = state[1];
    assign res_valid = state[0];
    assign mcd_a     = op_a;
    assign mcd_b     = op_b;
    assign mcd_c     = op_c;
    assign accept    = gnt_found & s1_free;

    // First valid requester at or above the pointer, wrapping modulo N_REQ
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        gnt_found = 1'b0;
        gnt_id    = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N_REQ)) begin
                sum = sum - (IDW+1)'(N_REQ);
            end
            idx = sum[IDW-1:0];
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_id == IDW'(k)) begin
                sel_a = req_a[k*W +: W];
                sel_b = req_b[k*W +: W];
                sel_c = req_c[k*W +: W];
            end
        end
    end

    // Gated by rst_n so the handshake is idle for the whole reset window
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready[k] = rst_n & accept & (gnt_id == IDW'(k));
        end
    end

    always_comb begin
        state_nxt = state;
        s1_free   = 1'b0;
        s2_load   = 1'b0;
        unique case (state)
            EMPTY: begin
                s1_free = 1'b1;
                if (gnt_found) begin
                    state_nxt = S1;
                end
            end
            S1: begin
                s1_free   = 1'b1;
                s2_load   = 1'b1;
                state_nxt = gnt_found ? FULL : S2;
            end
            S2: begin
                s1_free = 1'b1;
                if (res_ready) begin
                    state_nxt = gnt_found ? S1 : EMPTY;
                end else begin
                    state_nxt = gnt_found ? FULL : S2;
                end
            end
            FULL: begin
                if (res_ready) begin
                    s1_free   = 1'b1;
                    s2_load   = 1'b1;
                    state_nxt = gnt_found ? FULL : S2;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_id <= '0;
            op_a  <= '0;
            op_b  <= '0;
            op_c  <= '0;
        end else if (accept) begin
            op_id <= gnt_id;
            op_a  <= sel_a;
            op_b  <= sel_b;
            op_c  <= sel_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_id   <= '0;
            res_data <= '0;
        end else if (s2_load) begin
            res_id   <= op_id;
            res_data <= mcd_median;
        end
    end

`ifdef MEDIAN_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (res_valid && res_ready && done_cnt != 16'hFFFF) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_median_rr_arbiter.sv
// Directed bench for median_rr_arbiter with a behavioural median unit on mcd_*.
// Checks done_cnt as well when MEDIAN_ARB_STATS_EN is defined.
module tb_median_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] req_c;
    logic [7:0]  mcd_a;
    logic [7:0]  mcd_b;
    logic [7:0]  mcd_c;
    logic [7:0]  mcd_median;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [7:0]  res_data;
`ifdef MEDIAN_ARB_STATS_EN
    logic [15:0] done_cnt;
`endif

    int vectors;
    int miscompares;
    logic [7:0] t2_exp [4];

    median_rr_arbiter #(.N_REQ(4), .W(8), .IDW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .mcd_a      (mcd_a),
        .mcd_b      (mcd_b),
        .mcd_c      (mcd_c),
        .mcd_median (mcd_median),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_data   (res_data)
`ifdef MEDIAN_ARB_STATS_EN
        ,
        .done_cnt   (done_cnt)
`endif
    );

    function automatic logic [7:0] med3(input logic [7:0] a, b, c);
        if ((a >= b && a <= c) || (a <= b && a >= c)) return a;
        if ((b >= a && b <= c) || (b <= a && b >= c)) return b;
        return c;
    endfunction

    assign mcd_median = med3(mcd_a, mcd_b, mcd_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, b, c);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_c[i*8 +: 8] = c;
    endtask

    task automatic chk_res(input string tag, input logic [1:0] id,
                           input logic [7:0] data);
        chk({tag, "_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_id"}, 32'(res_id), 32'(id));
        chk({tag, "_data"}, 32'(res_data), 32'(data));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_c       = '0;
        res_ready   = 1'b0;
        t2_exp[0]   = 8'h20;
        t2_exp[1]   = 8'h02;
        t2_exp[2]   = 8'h80;
        t2_exp[3]   = 8'h44;

        // Reset values
        #2;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_id", 32'(res_id), 32'h0);
        chk("rst_res_data", 32'(res_data), 32'h0);
        chk("rst_mcd_a", 32'(mcd_a), 32'h0);
`ifdef MEDIAN_ARB_STATS_EN
        chk("rst_done_cnt", 32'(done_cnt), 32'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // T2: all requesting, grants rotate 0..3 twice, one result per cycle
        set_op(0, 8'h30, 8'h10, 8'h20);
        set_op(1, 8'h01, 8'h02, 8'h03);
        set_op(2, 8'hFF, 8'h00, 8'h80);
        set_op(3, 8'h44, 8'h44, 8'h11);
        res_ready = 1'b1;
        req_valid = 4'b1111;
        for (int j = 0; j < 10; j++) begin
            if (j == 8) req_valid = 4'b0000;
            #1;
            if (j < 8) chk("t2_ready", 32'(req_ready), 32'(1 << (j % 4)));
            if (j >= 2) chk_res("t2_res", 2'((j - 2) % 4), t2_exp[(j - 2) % 4]);
            else chk("t2_res_valid", 32'(res_valid), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("t2_idle", 32'(res_valid), 32'd0);

        // T1: single request from 0
        set_op(0, 8'h20, 8'h80, 8'h04);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("t1_s1_res_valid", 32'(res_valid), 32'd0);
        chk("t1_mcd_a", 32'(mcd_a), 32'h20);
        chk("t1_mcd_b", 32'(mcd_b), 32'h80);
        chk("t1_mcd_c", 32'(mcd_c), 32'h04);
        @(negedge clk);
        #1;
        chk_res("t1_res", 2'd0, 8'h20);
        @(negedge clk);
        #1;
        chk("t1_idle", 32'(res_valid), 32'd0);

        // T5: ties and ordering, back-to-back accepts from 1 then 2
        set_op(1, 8'h10, 8'h10, 8'hFF);
        req_valid = 4'b0010;
        #1;
        chk("t5_ready1", 32'(req_ready), 32'h2);
        @(negedge clk);
        set_op(2, 8'h01, 8'h80, 8'h20);
        req_valid = 4'b0100;
        #1;
        chk("t5_ready2", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk_res("t5_res1", 2'd1, 8'h10);
        @(negedge clk);
        #1;
        chk_res("t5_res2", 2'd2, 8'h20);
        @(negedge clk);
        #1;
        chk("t5_idle", 32'(res_valid), 32'd0);

        // T3: pointer at 3, requests 0 and 2 only
        set_op(0, 8'h05, 8'h03, 8'h09);
        set_op(2, 8'h07, 8'h07, 8'h07);
        req_valid = 4'b0101;
        #1;
        chk("t3_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        #1;
        chk("t3_grant2", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk_res("t3_res0", 2'd0, 8'h05);
        @(negedge clk);
        #1;
        chk_res("t3_res2", 2'd2, 8'h07);
        @(negedge clk);
        #1;
        chk("t3_idle", 32'(res_valid), 32'd0);

        // T4: backpressure fills both stages, then drain with a same-cycle accept
        res_ready = 1'b0;
        set_op(3, 8'h09, 8'h01, 8'h05);
        set_op(0, 8'h60, 8'h70, 8'h50);
        req_valid = 4'b1001;
        #1;
        chk("t4_grant3", 32'(req_ready), 32'h8);
        @(negedge clk);
        #1;
        chk("t4_grant0", 32'(req_ready), 32'h1);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            #1;
            chk("t4_full_ready", 32'(req_ready), 32'h0);
            chk_res("t4_full_res", 2'd3, 8'h05);
            chk("t4_full_mcd_a", 32'(mcd_a), 32'h60);
            chk("t4_full_mcd_b", 32'(mcd_b), 32'h70);
        end
        res_ready = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("t4_drain_accept", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk_res("t4_out0", 2'd0, 8'h60);
        @(negedge clk);
        #1;
        chk_res("t4_out3", 2'd3, 8'h05);
        @(negedge clk);
        #1;
        chk("t4_idle", 32'(res_valid), 32'd0);

        // T6: reset while FULL
        res_ready = 1'b0;
        set_op(1, 8'hAA, 8'hBB, 8'hCC);
        req_valid = 4'b0010;
        @(negedge clk);
        set_op(2, 8'h10, 8'h30, 8'h20);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b1010;
        #1;
        chk("t6_full_valid", 32'(res_valid), 32'd1);
        chk("t6_full_ready", 32'(req_ready), 32'h0);
`ifdef MEDIAN_ARB_STATS_EN
        chk("t6_done_cnt", 32'(done_cnt), 32'd16);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 32'(req_ready), 32'h0);
        chk("t6_rst_valid", 32'(res_valid), 32'd0);
        chk("t6_rst_id", 32'(res_id), 32'd0);
        chk("t6_rst_data", 32'(res_data), 32'd0);
        chk("t6_rst_mcd", 32'({mcd_a, mcd_b, mcd_c}), 32'd0);
`ifdef MEDIAN_ARB_STATS_EN
        chk("t6_rst_done_cnt", 32'(done_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        set_op(1, 8'h22, 8'h11, 8'h33);
        #1;
        chk("t6_first_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        chk("t6_no_stale", 32'(res_valid), 32'd0);
        @(negedge clk);
        #1;
        chk_res("t6_res", 2'd1, 8'h22);
        @(negedge clk);
        #1;
        chk("t6_idle", 32'(res_valid), 32'd0);
`ifdef MEDIAN_ARB_STATS_EN
        chk("t6_done_after", 32'(done_cnt), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
